lane_collector: RTL and testbench

- Serial-to-parallel lane collector that feeds the existing N-way data demultiplexer stage in the feature-map datapath.
- Accepts a stream of DATA_WIDTH words over a valid/ready handshake and routes word k of a group to lane k, k = 0..N-1.
- Emits the completed group as one N*DATA_WIDTH vector with the same lane packing as the demultiplexer: lane 0 in the MSB slice.
- Double-buffered (collection register plus output register), so it sustains one word per cycle while the consumer keeps out_ready high.

---
 rtl/lane_collector_pkg.sv | 13 +
 rtl/lane_collector_if.sv | 25 ++
 rtl/lane_collector_demux.sv | 28 ++
 rtl/lane_collector.sv | 156 +++++++++++++++
 tb/tb_lane_collector.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_collector_pkg.sv
// Shared constants and helpers for the lane collector: control state encoding
// and the lane-pointer width function.
package lane_collector_pkg;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  // Lane pointer width; a single-lane collector still carries a 1-bit pointer.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lane_collector_if.sv
// Input word stream and output group stream of the lane collector.
interface lane_collector_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_WIDTH-1:0] out_data;
  logic [N-1:0]          out_mask;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_last
  );
endinterface

// File: rtl/lane_collector_demux.sv
// N-way word demultiplexer: routes data_i to lane sel_i and raises that lane's
// write enable. Lane 0 occupies the MSB slice and MSB enable bit.
module lane_collector_demux
  import lane_collector_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned N          = 4,
  localparam int unsigned SEL_WIDTH  = clog2_min1(N)
) (
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [SEL_WIDTH-1:0]    sel_i,
  input  logic                    en_i,
  output logic [N*DATA_WIDTH-1:0] lanes_o,
  output logic [N-1:0]            we_o
);

  always_comb begin
    lanes_o = '0;
    we_o    = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (en_i && (sel_i == SEL_WIDTH'(j))) begin
        lanes_o[N*DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = data_i;
        we_o[N-1-j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_collector.sv
// Serial-to-parallel lane collector: gathers N words into one group, with a
// collection register and an output register so it streams at one word/cycle.
module lane_collector
  import lane_collector_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned N          = 4,
  localparam int unsigned SEL_WIDTH  = clog2_min1(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  lane_collector_if.slave      bus,
  output logic [SEL_WIDTH-1:0] lane_sel
);

  logic                    rdy_q;
  logic [0:0]              state_q,     state_d;
  logic [SEL_WIDTH-1:0]    sel_q,       sel_d;
  logic [N*DATA_WIDTH-1:0] coll_data_q, coll_data_d;
  logic [N-1:0]            coll_mask_q, coll_mask_d;
  logic                    pend_last_q, pend_last_d;
  logic                    out_valid_q, out_valid_d;
  logic [N*DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [N-1:0]            out_mask_q,  out_mask_d;
  logic                    out_last_q,  out_last_d;

  logic                    in_ready;
  logic                    accept;
  logic                    complete;
  logic                    slot_free;
  logic [N*DATA_WIDTH-1:0] lanes;
  logic [N-1:0]            lane_we;
  logic [N*DATA_WIDTH-1:0] merged_data;
  logic [N-1:0]            merged_mask;

  assign in_ready  = rdy_q && (state_q == COLLECT);
  assign accept    = bus.in_valid && in_ready && !clear;
  assign complete  = accept && ((sel_q == SEL_WIDTH'(N-1)) || bus.in_last);
  assign slot_free = !out_valid_q || bus.out_ready;

  lane_collector_demux #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_demux (
    .data_i  (bus.in_data),
    .sel_i   (sel_q),
    .en_i    (accept),
    .lanes_o (lanes),
    .we_o    (lane_we)
  );

  always_comb begin
    merged_data = coll_data_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (lane_we[N-1-j]) begin
        merged_data[N*DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] =
          lanes[N*DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH];
      end
    end
    merged_mask = coll_mask_q | lane_we;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    coll_data_d = coll_data_q;
    coll_mask_d = coll_mask_q;
    pend_last_d = pend_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (state_q == HOLD) begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_data_d  = coll_data_q;
        out_mask_d  = coll_mask_q;
        out_last_d  = pend_last_q;
        coll_data_d = '0;
        coll_mask_d = '0;
        pend_last_d = 1'b0;
        state_d     = COLLECT;
      end
    end else if (accept) begin
      sel_d = complete ? '0 : sel_q + SEL_WIDTH'(1);
      // A completing word bypasses the collection register when the slot is free.
      if (complete && slot_free) begin
        out_valid_d = 1'b1;
        out_data_d  = merged_data;
        out_mask_d  = merged_mask;
        out_last_d  = bus.in_last;
        coll_data_d = '0;
        coll_mask_d = '0;
      end else begin
        coll_data_d = merged_data;
        coll_mask_d = merged_mask;
        if (complete) begin
          pend_last_d = bus.in_last;
          state_d     = HOLD;
        end
      end
    end

    if (clear) begin
      state_d     = COLLECT;
      sel_d       = '0;
      coll_data_d = '0;
      coll_mask_d = '0;
      pend_last_d = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_mask_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      state_q     <= COLLECT;
      sel_q       <= '0;
      coll_data_q <= '0;
      coll_mask_q <= '0;
      pend_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      state_q     <= state_d;
      sel_q       <= sel_d;
      coll_data_q <= coll_data_d;
      coll_mask_q <= coll_mask_d;
      pend_last_q <= pend_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_last  = out_last_q;
  assign lane_sel      = sel_q;

endmodule

// File: tb/tb_lane_collector.sv
// Directed bench for lane_collector (DATA_WIDTH=8, N=4): vector table plus
// hand sequences for reset, clear and streaming throughput.
module tb_lane_collector;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [1:0] lane_sel;

  int checks = 0;
  int errors = 0;

  lane_collector_if #(.DATA_WIDTH(8), .N(4)) bus ();

  lane_collector #(
    .DATA_WIDTH (8),
    .N          (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus.slave),
    .lane_sel (lane_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        clr;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic        exp_last;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic ordy, logic clr,
                              logic ir, logic ov, logic [31:0] data, logic [3:0] mask,
                              logic last, logic [1:0] sel);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.ordy = ordy; t.clr = clr;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_data = data; t.exp_mask = mask;
    t.exp_last = last; t.exp_sel = sel;
    return t;
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clear         = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input bit toggle, input logic [7:0] base);
    int         sent = 0;
    int         got = 0;
    int         cyc = 0;
    int         done_cyc = -1;
    logic       acc;
    logic       take;
    logic [31:0] grp;
    logic [7:0] b0;
    clear = 1'b0;
    while (got < 8 && cyc < 400) begin
      bus.in_valid  = (sent < 32);
      bus.in_data   = base + 8'(sent);
      bus.in_last   = 1'b0;
      bus.out_ready = toggle ? ~cyc[0] : 1'b1;
      #1;
      acc  = bus.in_valid && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      grp  = bus.out_data;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent == 32) done_cyc = cyc + 1;
      end
      if (take) begin
        b0 = base + 8'(4 * got);
        chk($sformatf("stream%0d_grp%0d", toggle, got), 64'(grp),
            64'({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}));
        got++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk($sformatf("stream%0d_groups", toggle), 64'(got), 64'd8);
    chk($sformatf("stream%0d_sent", toggle), 64'(sent), 64'd32);
    if (!toggle) chk("stream_accept_cycles", 64'(done_cyc), 64'd32);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_mask", 64'(bus.out_mask), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_lane_sel", 64'(lane_sel), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back group, backpressure, early close, last on lane N-1
    tbl.push_back(mk(1, 8'h11, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'h22, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd2));
    tbl.push_back(mk(1, 8'h33, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd3));
    tbl.push_back(mk(1, 8'h44, 0, 1, 0, 1, 1, 32'h11223344, 4'hF, 0, 2'd0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd0));
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'h02, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 2'd2));
    tbl.push_back(mk(1, 8'h03, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 2'd3));
    tbl.push_back(mk(1, 8'h04, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0, 2'd0));
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0, 2'd1));
    tbl.push_back(mk(1, 8'h06, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0, 2'd2));
    tbl.push_back(mk(1, 8'h07, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0, 2'd3));
    tbl.push_back(mk(1, 8'h08, 0, 0, 0, 1, 1, 32'h01020304, 4'hF, 0, 2'd0));
    tbl.push_back(mk(1, 8'h09, 0, 0, 0, 0, 1, 32'h01020304, 4'hF, 0, 2'd0));
    tbl.push_back(mk(1, 8'h09, 0, 1, 0, 0, 1, 32'h05060708, 4'hF, 0, 2'd0));
    tbl.push_back(mk(1, 8'h09, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'h0A, 1, 1, 0, 1, 1, 32'h090A0000, 4'hC, 1, 2'd0));
    tbl.push_back(mk(1, 8'hAA, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'hBB, 1, 1, 0, 1, 1, 32'hAABB0000, 4'hC, 1, 2'd0));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd0));
    tbl.push_back(mk(1, 8'hCC, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'hDD, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd2));
    tbl.push_back(mk(1, 8'hEE, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd3));
    tbl.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 1, 32'hCCDDEEFF, 4'hF, 0, 2'd0));
    tbl.push_back(mk(1, 8'h41, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd1));
    tbl.push_back(mk(1, 8'h42, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd2));
    tbl.push_back(mk(1, 8'h43, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd3));
    tbl.push_back(mk(1, 8'h44, 1, 1, 0, 1, 1, 32'h41424344, 4'hF, 1, 2'd0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 4'h0, 0, 2'd0));

    foreach (tbl[i]) begin
      bus.in_valid  = tbl[i].v;
      bus.in_data   = tbl[i].d;
      bus.in_last   = tbl[i].l;
      bus.out_ready = tbl[i].ordy;
      clear         = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
      if (tbl[i].exp_ov) begin
        chk($sformatf("v%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].exp_data));
        chk($sformatf("v%0d_out_mask", i), 64'(bus.out_mask), 64'(tbl[i].exp_mask));
        chk($sformatf("v%0d_out_last", i), 64'(bus.out_last), 64'(tbl[i].exp_last));
      end
      chk($sformatf("v%0d_lane_sel", i), 64'(lane_sel), 64'(tbl[i].exp_sel));
    end

    // Asynchronous reset in the middle of a group
    drive(1, 8'h10, 0, 1, 0);
    drive(1, 8'h20, 0, 1, 0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_data", 64'(bus.out_data), 64'd0);
    chk("arst_out_mask", 64'(bus.out_mask), 64'd0);
    chk("arst_lane_sel", 64'(lane_sel), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_in_ready", 64'(bus.in_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_release_in_ready", 64'(bus.in_ready), 64'd1);
    drive(1, 8'h31, 0, 1, 0);
    drive(1, 8'h32, 0, 1, 0);
    drive(1, 8'h33, 0, 1, 0);
    drive(1, 8'h34, 0, 1, 0);
    chk("arst_after_valid", 64'(bus.out_valid), 64'd1);
    chk("arst_after_data", 64'(bus.out_data), 64'h31323334);
    chk("arst_after_mask", 64'(bus.out_mask), 64'hF);
    chk("arst_after_last", 64'(bus.out_last), 64'd0);

    // clear on the completing word, then clear of a pending output group
    drive(1, 8'h01, 0, 1, 0);
    drive(1, 8'h02, 0, 1, 0);
    drive(1, 8'h03, 0, 1, 0);
    drive(1, 8'h04, 0, 1, 1);
    chk("clr_word_out_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_word_lane_sel", 64'(lane_sel), 64'd0);
    drive(0, 8'h00, 0, 1, 0);
    chk("clr_word_no_pulse", 64'(bus.out_valid), 64'd0);
    drive(1, 8'h05, 0, 0, 0);
    drive(1, 8'h06, 0, 0, 0);
    drive(1, 8'h07, 0, 0, 0);
    drive(1, 8'h08, 0, 0, 0);
    chk("clr_pend_before", 64'(bus.out_valid), 64'd1);
    drive(0, 8'h00, 0, 0, 1);
    chk("clr_pend_out_valid", 64'(bus.out_valid), 64'd0);
    drive(0, 8'h00, 0, 0, 0);
    chk("clr_pend_stays_low", 64'(bus.out_valid), 64'd0);
    drive(1, 8'h09, 0, 1, 0);
    drive(1, 8'h0A, 1, 1, 0);
    chk("clr_after_data", 64'(bus.out_data), 64'h090A0000);
    chk("clr_after_mask", 64'(bus.out_mask), 64'hC);
    drive(0, 8'h00, 0, 1, 0);

    // Streaming: toggling backpressure, then full rate
    run_stream(1'b1, 8'h80);
    drive(0, 8'h00, 0, 1, 0);
    run_stream(1'b0, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
